// File: rtl/lsu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_pkg : funct3 codes, FSM encoding and helpers for the load/store unit  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package lsu_pkg;

    localparam int MEM_AW_DEF = 5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

    // Access size in bytes (1, 2 or 4) from the low funct3 bits.
    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   f3_size = 3'd1;
            2'b01:   f3_size = 3'd2;
            default: f3_size = 3'd4;
        endcase
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) f3_legal = f3 inside {F3_B, F3_H, F3_W};
        else    f3_legal = f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_if : core request/response and data-memory signals of the LSU         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface lsu_if
    import lsu_pkg::*;
#(
    parameter int MEM_AW = MEM_AW_DEF
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wd;
    logic [31:0]       mem_rd;

    // master: core plus data memory; slave: the load/store unit
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wd
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wd
    );
endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_align : byte-lane enables, store merge and load extract/extension     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    input  logic        i_hi_part,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_merge_base,
    input  logic [31:0] i_lo_word,
    input  logic [31:0] i_hi_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_wd,
    output logic [31:0] o_rdata
);
    logic [3:0]  w_mask;
    logic [7:0]  w_be8;
    logic [63:0] w_wshift;
    logic [31:0] w_lane_data;
    logic [31:0] w_raw;

    always_comb begin
        case (f3_size(i_funct3))
            3'd1:    w_mask = 4'b0001;
            3'd2:    w_mask = 4'b0011;
            default: w_mask = 4'b1111;
        endcase
        // An 8-byte window spans word A (lanes 3:0) and word A+1 (lanes 7:4).
        w_be8       = {4'b0000, w_mask} << i_off;
        w_wshift    = {32'd0, i_wdata} << {i_off, 3'b000};
        o_be        = i_hi_part ? w_be8[7:4] : w_be8[3:0];
        w_lane_data = i_hi_part ? w_wshift[63:32] : w_wshift[31:0];

        o_wd = i_merge_base;
        for (int i = 0; i < 4; i++) begin
            if (o_be[i]) o_wd[8*i +: 8] = w_lane_data[8*i +: 8];
        end

        w_raw = 32'({i_hi_word, i_lo_word} >> {i_off, 3'b000});
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_raw[7]}}, w_raw[7:0]};
            F3_H:    o_rdata = {{16{w_raw[15]}}, w_raw[15:0]};
            F3_BU:   o_rdata = {24'd0, w_raw[7:0]};
            F3_HU:   o_rdata = {16'd0, w_raw[15:0]};
            default: o_rdata = w_raw;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_ctrl : load/store unit FSM; LSU_MISALIGN_EN enables word-crossing     |
// | accesses in two cycles, otherwise misaligned accesses are rejected.       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_AW = MEM_AW_DEF
) (
    input  logic clk,
    input  logic reset,
    lsu_if.slave bus
);
    state_t      state_q, state_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic [MEM_AW-1:0] w_req_word;
    logic [1:0]        w_req_off;
    logic [2:0]        w_size;
    logic              w_legal;
    logic              w_bad_align;
    logic              w_accept;
    logic [1:0]        a_off;
    logic [2:0]        a_f3;
    logic [31:0]       a_wdata;
    logic [31:0]       a_lo;
    logic              a_hi_part;
    logic [3:0]        w_be;
    logic [31:0]       w_wd;
    logic [31:0]       w_rdata;
    logic              unused_addr_hi;

    assign w_req_word     = bus.req_addr[MEM_AW+1:2];
    assign w_req_off      = bus.req_addr[1:0];
    assign w_size         = f3_size(bus.req_funct3);
    assign w_legal        = f3_legal(bus.req_we, bus.req_funct3);
    assign w_accept       = bus.req_valid & bus.req_ready;
    assign unused_addr_hi = ^{bus.req_addr[31:MEM_AW+2], w_be};

`ifdef LSU_MISALIGN_EN
    logic [1:0]        off_q, off_d;
    logic [2:0]        f3_q, f3_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       lo_q, lo_d;
    logic [MEM_AW-1:0] word_q, word_d;
    logic              w_cross;

    assign w_cross     = ({2'b00, w_req_off} + {1'b0, w_size}) > 4'd4;
    assign w_bad_align = 1'b0;

    always_comb begin
        a_hi_part = (state_q == ST_SECOND);
        a_off     = a_hi_part ? off_q   : w_req_off;
        a_f3      = a_hi_part ? f3_q    : bus.req_funct3;
        a_wdata   = a_hi_part ? wdata_q : bus.req_wdata;
        a_lo      = a_hi_part ? lo_q    : bus.mem_rd;
    end
`else
    assign w_bad_align = (w_req_off & 2'(w_size - 3'd1)) != 2'b00;

    always_comb begin
        a_hi_part = 1'b0;
        a_off     = w_req_off;
        a_f3      = bus.req_funct3;
        a_wdata   = bus.req_wdata;
        a_lo      = bus.mem_rd;
    end
`endif

    lsu_align u_align (
        .i_off        (a_off),
        .i_funct3     (a_f3),
        .i_hi_part    (a_hi_part),
        .i_wdata      (a_wdata),
        .i_merge_base (bus.mem_rd),
        .i_lo_word    (a_lo),
        .i_hi_word    (bus.mem_rd),
        .o_be         (w_be),
        .o_wd         (w_wd),
        .o_rdata      (w_rdata)
    );

    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        // Gating with reset keeps mem_we low while reset is held.
        bus.req_ready = (state_q == ST_IDLE) & ~reset;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = w_req_word;
        bus.mem_wd    = w_wd;
`ifdef LSU_MISALIGN_EN
        off_d   = off_q;
        f3_d    = f3_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        word_d  = word_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    resp_rdata_d = 32'd0;
                    resp_err_d   = 1'b0;
                    if (!w_legal || w_bad_align) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end
`ifdef LSU_MISALIGN_EN
                    else if (w_cross) begin
                        bus.mem_we = bus.req_we;
                        lo_d       = bus.mem_rd;
                        off_d      = w_req_off;
                        f3_d       = bus.req_funct3;
                        we_d       = bus.req_we;
                        wdata_d    = bus.req_wdata;
                        word_d     = w_req_word + MEM_AW'(1);
                        state_d    = ST_SECOND;
                    end
`endif
                    else begin
                        bus.mem_we   = bus.req_we;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = bus.req_we ? 32'd0 : w_rdata;
                    end
                end
            end
`ifdef LSU_MISALIGN_EN
            ST_SECOND: begin
                bus.mem_addr = word_q;
                bus.mem_we   = we_q;
                resp_valid_d = 1'b1;
                resp_rdata_d = we_q ? 32'd0 : w_rdata;
                state_d      = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
`ifdef LSU_MISALIGN_EN
            off_q        <= 2'd0;
            f3_q         <= 3'd0;
            we_q         <= 1'b0;
            wdata_q      <= 32'd0;
            lo_q         <= 32'd0;
            word_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
`ifdef LSU_MISALIGN_EN
            off_q        <= off_d;
            f3_q         <= f3_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            lo_q         <= lo_d;
            word_q       <= word_d;
`endif
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lsu_ctrl : directed self-checking bench for lsu_ctrl with memory model |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lsu_if #(.MEM_AW(5)) bus ();

    lsu_ctrl #(.MEM_AW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [32];
    int          n_wr = 0;

    assign bus.mem_rd = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wd;
            n_wr              <= n_wr + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_rdy;
    int          r_lat;

    // Drive one request, then wait (bounded) for the response pulse.
    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        chk("ready_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        r_rdy = bus.req_ready;
        r_lat = 1;
        while (!bus.resp_valid && r_lat < 6) begin
            @(posedge clk);
            #1;
            r_lat++;
        end
        r_rdata = bus.resp_rdata;
        r_err   = bus.resp_err;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr0;
        int pulses;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;

        #2;
        chk("rst_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'd0);
        chk("rst_err",   32'(bus.resp_err), 32'd0);
        chk("rst_we",    32'(bus.mem_we), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // SW then LW, aligned
        issue(1'b1, F3_W, 32'h08, 32'hDEADBEEF);
        chk("sw_lat", 32'(r_lat), 32'd1);
        chk("sw_rdata", r_rdata, 32'd0);
        chk("sw_mem2", mem[2], 32'hDEADBEEF);
        issue(1'b0, F3_W, 32'h08, 32'd0);
        chk("lw_rdata", r_rdata, 32'hDEADBEEF);
        chk("lw_lat", 32'(r_lat), 32'd1);
        chk("lw_rdy", 32'(r_rdy), 32'd1);
        @(posedge clk);
        #1;
        chk("lw_pulse", 32'(bus.resp_valid), 32'd0);
        chk("lw_hold", bus.resp_rdata, 32'hDEADBEEF);

        // Byte store and signed/unsigned byte loads
        issue(1'b1, F3_B, 32'h09, 32'h00000080);
        chk("sb_mem2", mem[2], 32'hDEAD80EF);
        issue(1'b0, F3_B, 32'h09, 32'd0);
        chk("lb_rdata", r_rdata, 32'hFFFFFF80);
        issue(1'b0, F3_BU, 32'h09, 32'd0);
        chk("lbu_rdata", r_rdata, 32'h00000080);

        // Halfword merge
        issue(1'b1, F3_W, 32'h04, 32'hAAAAAAAA);
        issue(1'b1, F3_H, 32'h06, 32'h00001234);
        chk("sh_mem1", mem[1], 32'h1234AAAA);
        issue(1'b0, F3_H, 32'h06, 32'd0);
        chk("lh_rdata", r_rdata, 32'h00001234);

        // Word-crossing load
        issue(1'b1, F3_W, 32'h08, 32'h11223344);
        issue(1'b1, F3_W, 32'h0C, 32'h55667788);
        wr0 = n_wr;
        issue(1'b0, F3_W, 32'h0B, 32'd0);
        chk("xlw_writes", 32'(n_wr - wr0), 32'd0);
`ifdef LSU_MISALIGN_EN
        chk("xlw_rdy", 32'(r_rdy), 32'd0);
        chk("xlw_lat", 32'(r_lat), 32'd2);
        chk("xlw_rdata", r_rdata, 32'h66778811);
        chk("xlw_err", 32'(r_err), 32'd0);
`else
        chk("xlw_lat", 32'(r_lat), 32'd1);
        chk("xlw_rdata", r_rdata, 32'd0);
        chk("xlw_err", 32'(r_err), 32'd1);
`endif

        // Non-natural halfword inside one word
        issue(1'b1, F3_W, 32'h00, 32'h00C0FFEE);
        issue(1'b0, F3_H, 32'h01, 32'd0);
`ifdef LSU_MISALIGN_EN
        chk("lh1_rdata", r_rdata, 32'hFFFFC0FF);
        chk("lh1_lat", 32'(r_lat), 32'd1);
`else
        chk("lh1_rdata", r_rdata, 32'd0);
        chk("lh1_err", 32'(r_err), 32'd1);
`endif

        // Crossing store at the top word wraps to word 0
        issue(1'b1, F3_W, 32'h7C, 32'h11112222);
        issue(1'b1, F3_W, 32'h00, 32'h33334444);
        issue(1'b1, F3_W, 32'h7E, 32'hCAFEF00D);
`ifdef LSU_MISALIGN_EN
        chk("wrap_lat", 32'(r_lat), 32'd2);
        chk("wrap_mem31", mem[31], 32'hF00D2222);
        chk("wrap_mem0", mem[0], 32'h3333CAFE);
`else
        chk("wrap_err", 32'(r_err), 32'd1);
        chk("wrap_mem31", mem[31], 32'h11112222);
        chk("wrap_mem0", mem[0], 32'h33334444);
`endif

        // Upper address bits ignored
        issue(1'b0, F3_W, 32'hFFFFFF88, 32'd0);
        chk("hiaddr_rdata", r_rdata, 32'h11223344);
        chk("hiaddr_err", 32'(r_err), 32'd0);

        // Illegal funct3 for load and for store
        wr0 = n_wr;
        issue(1'b0, 3'b011, 32'h08, 32'd0);
        chk("f3_011_err", 32'(r_err), 32'd1);
        chk("f3_011_rdata", r_rdata, 32'd0);
        issue(1'b1, F3_BU, 32'h08, 32'hFFFFFFFF);
        chk("st_f3bu_err", 32'(r_err), 32'd1);
        chk("st_f3bu_writes", 32'(n_wr - wr0), 32'd0);
        chk("st_f3bu_mem2", mem[2], 32'h11223344);

`ifdef LSU_MISALIGN_EN
        // Reset while the second half of a crossing store is pending
        issue(1'b1, F3_W, 32'h10, 32'h11111111);
        issue(1'b1, F3_W, 32'h14, 32'h22222222);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h12;
        bus.req_wdata  = 32'hA1B2C3D4;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        chk("rst2_rdy_second", 32'(bus.req_ready), 32'd0);
        reset  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid) pulses++;
            if (i == 0) reset = 1'b0;
        end
        chk("rst2_pulses", 32'(pulses), 32'd0);
        chk("rst2_mem4", mem[4], 32'hC3D41111);
        chk("rst2_mem5", mem[5], 32'h22222222);
        chk("rst2_rdy_idle", 32'(bus.req_ready), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
